stripe_ctrl12: RTL
==================

STRIPE_CTRL12 -- requirements
Module: stripe_ctrl12

Interface
REQ-001 Parameter DATA_W, default 8, byte width of every data path.
REQ-002 Parameter DEPTH, default 4, entries per lane FIFO; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in  input  DATA_W  upstream byte.
REQ-006 valid  input  1  upstream byte present.
REQ-007 ready  output  1  controller accepts the byte; transfer occurs when valid && ready.
REQ-008 mode_x2  input  1  1 = stripe across lanes 0/1; 0 = lane 0 only.
REQ-009 out0 / out1  output  DATA_W  head byte of lane 0 / lane 1 FIFO.
REQ-010 valid_out  output  2  bit i set when lane i FIFO is non-empty.
REQ-011 pop  input  2  lane i consumes its head when valid_out[i] && pop[i]; pop on an empty lane is ignored.

Function
REQ-012 FSM states: IDLE, X1, X2, DRAIN.
REQ-013 IDLE: ready=0; the next cycle moves to X2 if mode_x2=1, otherwise to X1; the lane pointer sel is cleared to 0.
REQ-014 X1: every accepted byte goes to lane 0; ready = !full0.
REQ-015 X2: an accepted byte goes to lane sel, then sel toggles; ready = !full[sel]; sel never advances without a transfer.
REQ-016 In X1/X2, mode_x2 differing from the current state moves the FSM to DRAIN on the next cycle; a transfer in the same cycle still completes.
REQ-017 DRAIN: ready=0; pops continue; when both FIFOs are empty, the FSM moves to IDLE on the next cycle.
REQ-018 Latency: a byte accepted in cycle N into an empty FIFO appears on out_i with valid_out[i]=1 in cycle N+1.
REQ-019 out_i reads the FIFO head combinationally from storage registers; its value is don't-care while valid_out[i]=0.
REQ-020 Push and pop on the same non-full, non-empty FIFO in one cycle leaves the occupancy unchanged and preserves order.
REQ-021 There is no pass-through; a full FIFO blocks its push even when popped in the same cycle.
REQ-022 FIFO pointers are log2(DEPTH) bits wide, wrap modulo DEPTH, and use an extra bit to distinguish full from empty.
REQ-023 Per-lane byte order equals acceptance order; in X2, lane 0 holds even-indexed bytes and lane 1 holds odd-indexed bytes, counted from IDLE.

Reset
REQ-024 While reset=1 at a clock edge, the controller enters IDLE, sel=0, and both FIFOs become empty.
REQ-025 During and after reset, ready=0 and valid_out=2'b00.
REQ-026 Reset asserted mid-transfer discards all buffered bytes; no partial byte survives.

Configuration
REQ-027 Macro STRIPE_CTRL12_STATS_EN defined: adds outputs cnt0 and cnt1, each 16 bits, counting bytes pushed into lane 0 / lane 1. Both counters saturate at 16'hFFFF and are cleared by reset.
REQ-028 Macro undefined: the cnt0/cnt1 ports and the counters are absent; all other behaviour is identical.

Structure
REQ-029 A shared package holds the state enum (IDLE, X1, X2, DRAIN), the lane-index constants LANE0=0 and LANE1=1, and the default DATA_W/DEPTH constants.
REQ-030 Sub-module lane_fifo is parameterized by DATA_W and DEPTH, has push/pop/full/empty/head ports, and is instantiated twice; FSM and sel logic stay in stripe_ctrl12.

Verification
REQ-031 Reset then mode_x2=1, pop=2'b11, stream 8'h01..8'h06 -> out0 shows 01,03,05; out1 shows 02,04,06; ready=1 from the second post-reset cycle.
REQ-032 mode_x2=0, pop=0, DEPTH=4, push 5 bytes -> ready drops after the 4th byte; valid_out=2'b01; the 5th byte is held upstream until one pop.
REQ-033 X2 with lane 1 full, sel=1, valid=1 -> ready=0 and sel stays 1; pop[1] for one cycle -> ready=1 on the next cycle and the byte lands in lane 1.
REQ-034 X2 with 3 bytes buffered, toggle mode_x2 to 0 -> DRAIN with ready=0 until both lanes are empty, then IDLE, then X1; the next byte goes to lane 0.
REQ-035 Push and pop on lane 0 simultaneously at occupancy 2 for 10 cycles -> occupancy stays 2 and output order is intact.
REQ-036 Reset asserted with both FIFOs full -> the next cycle shows valid_out=2'b00 and ready=0; with STRIPE_CTRL12_STATS_EN, cnt0=cnt1=0.

Source files
------------

// File: rtl/stripe_ctrl12_pkg.sv
// Shared types and constants for the stripe_ctrl12 two-lane byte striping controller.
package stripe_ctrl12_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    X1    = 2'd1,
    X2    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

endpackage

// File: rtl/stripe_ctrl12_lane_fifo.sv
// lane_fifo: per-lane FIFO with a combinational head read and wrap-bit full/empty pointers.
import stripe_ctrl12_pkg::*;

module lane_fifo #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push_en, pop_en;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // A full FIFO refuses the push even if the head is popped in the same cycle.
  always_comb begin
    push_en  = push && !full;
    pop_en   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/stripe_ctrl12.sv
// Byte striping controller: X1 feeds lane 0, X2 alternates lanes 0/1; mode change drains both lanes.
// Optional STRIPE_CTRL12_STATS_EN adds saturating per-lane push counters cnt0/cnt1.
import stripe_ctrl12_pkg::*;

module stripe_ctrl12 #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              valid,
  output logic              ready,
  input  logic              mode_x2,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [1:0]        valid_out,
  input  logic [1:0]        pop
`ifdef STRIPE_CTRL12_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   push0, push1;
  logic   full0, full1, empty0, empty1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ready   = 1'b0;
    push0   = 1'b0;
    push1   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d   = LANE0;
        state_d = mode_x2 ? X2 : X1;
      end
      X1: begin
        ready = !full0;
        push0 = valid && !full0;
        if (mode_x2) state_d = DRAIN;
      end
      X2: begin
        ready = (sel_q == LANE1) ? !full1 : !full0;
        // sel only advances on an actual transfer
        if (valid && ready) begin
          if (sel_q == LANE1) push1 = 1'b1;
          else                push0 = 1'b1;
          sel_d = ~sel_q;
        end
        if (!mode_x2) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty0 && empty1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= LANE0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop[0]),
    .din   (in),
    .full  (full0),
    .empty (empty0),
    .head  (out0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop[1]),
    .din   (in),
    .full  (full1),
    .empty (empty1),
    .head  (out1)
  );

  always_comb valid_out = {!empty1, !empty0};

`ifdef STRIPE_CTRL12_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 16'd1;
    if (push1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  always_comb begin
    cnt0 = cnt0_q;
    cnt1 = cnt1_q;
  end
`endif

endmodule
